srl2par: RTL and testbench
==========================

SRL2PAR -- requirements
Module: srl2par

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of serial bits per parallel word; legal range 2..32.
REQ-002 The block SHALL have parameter MSB_FIRST, default 0: 0 = first received bit lands in par[0]; 1 = first received bit lands in par[WIDTH-1].
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port srl, input, 1 bit: serial data bit.
REQ-006 Port srl_vld, input, 1 bit: srl is valid this cycle; when low, srl is ignored.
REQ-007 Port frm, input, 1 bit: when high with srl_vld, srl carries bit 0 of a new word.
REQ-008 Port par, output, WIDTH bits: last completed parallel word (registered).
REQ-009 Port par_vld, output, 1 bit: one-cycle pulse; par holds a newly completed word.
REQ-010 Port locked, output, 1 bit: high while the block is word-aligned.
REQ-011 Port frm_err, output, 1 bit: one-cycle pulse on a framing error.

Function
REQ-012 The block SHALL have two states: HUNT (not aligned) and RECV (aligned), plus a bit index cnt of ceil(log2(WIDTH)) bits and a WIDTH-bit shift register.
REQ-013 Only cycles with srl_vld=1 SHALL be accepted; with srl_vld=0, state, cnt and the shift register hold and par_vld/frm_err are 0.
REQ-014 In HUNT, an accepted bit with frm=0 SHALL be discarded; an accepted bit with frm=1 SHALL be stored as bit 0, with cnt set to 1 and the state moving to RECV.
REQ-015 In RECV, an accepted bit with frm=0 SHALL be stored at index cnt and cnt SHALL increment.
REQ-016 When the accepted bit is at index WIDTH-1, the assembled word SHALL be loaded into par, par_vld SHALL pulse, and cnt SHALL wrap to 0 with the state remaining RECV.
REQ-017 par and par_vld SHALL update on the clock edge that samples the last bit; they are visible in the following cycle, giving a latency of 1 clock.
REQ-018 In RECV with cnt=0, frm=1 SHALL be accepted as a normal word start; frm=0 SHALL also be accepted, giving free-running back-to-back words.
REQ-019 In RECV with cnt!=0, frm=1 (including at index WIDTH-1) SHALL pulse frm_err.
REQ-020 In that error case, the partial word SHALL be discarded, the current bit stored as bit 0, and cnt set to 1; par and par_vld SHALL NOT update.
REQ-021 par SHALL hold its value between completions; previously delivered words SHALL never be overwritten by a partial word.
REQ-022 locked SHALL be 1 exactly when the state is RECV.
REQ-023 Bit placement SHALL follow MSB_FIRST per REQ-002 for every word.

Reset
REQ-024 While rst=1: state=HUNT, cnt=0, shift register=0, par=0, par_vld=0, locked=0, frm_err=0, regardless of clk.
REQ-025 Reset asserted mid-word SHALL discard the partial word; after release, the block SHALL wait in HUNT for frm.
REQ-026 The first accepted edge SHALL be the first rising clk edge after rst deasserts.

Verification
REQ-027 WIDTH=4, MSB_FIRST=0: frm=1 on first bit, serial 1,0,1,1 on consecutive srl_vld cycles -> par=4'b1101 with par_vld one cycle after the 4th bit; locked=1 from the cycle after bit 0.
REQ-028 Same stream with MSB_FIRST=1 -> par=4'b1011.
REQ-029 Bits 1,1 with frm=0 while in HUNT, then frm=1 word 0,1,0,0 -> first two bits ignored; par=4'b0010.
REQ-030 Free-run: frm only on first bit, then 8 continuous bits 1,0,0,0,0,1,1,1 -> par_vld pulses twice; par=4'b0001, then 4'b1110.
REQ-031 frm=1 again at bit index 2, followed by 3 more bits -> frm_err pulses once; no par_vld for the broken word; the next par_vld carries the new word.
REQ-032 Gaps: srl_vld toggled 1/0 across a word -> same par as the gap-free case. rst pulsed after bit 2 -> par=0, locked=0, no par_vld until a new frm word completes.

Source files
------------

// File: rtl/srl2par_if.sv
// Serial-in / parallel-out bus between a bit source and the srl2par deserialiser.
// master drives the serial side, slave (the deserialiser) drives the word side.
interface srl2par_if #(
   parameter int unsigned WIDTH = 4
);
   logic             srl;
   logic             srl_vld;
   logic             frm;
   logic [WIDTH-1:0] par;
   logic             par_vld;
   logic             locked;
   logic             frm_err;

   modport master (
      output srl,
      output srl_vld,
      output frm,
      input  par,
      input  par_vld,
      input  locked,
      input  frm_err
   );

   modport slave (
      input  srl,
      input  srl_vld,
      input  frm,
      output par,
      output par_vld,
      output locked,
      output frm_err
   );
endinterface

// File: rtl/srl2par.sv
// Frame-aligned serial-to-parallel converter: hunts for frm, assembles WIDTH-bit
// words, reports completions on par/par_vld and misplaced frm as frm_err.
module srl2par #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic     clk,
   input  logic     rst,
   srl2par_if.slave bus
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [0:0] {StHunt, StRecv} state_e;

   state_e           state_q;
   logic [CntW-1:0]  cnt_q;
   logic [WIDTH-1:0] sh_q;
   logic [WIDTH-1:0] par_q;
   logic             par_vld_q;
   logic             frm_err_q;

   logic [CntW-1:0]  pos;
   logic [CntW-1:0]  pos0;
   logic [WIDTH-1:0] ins_word;
   logic [WIDTH-1:0] start_word;
   logic             last_bit;

   // Map logical bit index to its physical position in the word.
   always_comb begin
      pos        = MSB_FIRST ? (CntW'(WIDTH - 1) - cnt_q) : cnt_q;
      pos0       = MSB_FIRST ? CntW'(WIDTH - 1) : '0;
      ins_word   = (cnt_q == '0) ? '0 : sh_q;
      ins_word[pos] = bus.srl;
      start_word = '0;
      start_word[pos0] = bus.srl;
      last_bit   = (cnt_q == CntW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StHunt;
         cnt_q     <= '0;
         sh_q      <= '0;
         par_q     <= '0;
         par_vld_q <= 1'b0;
         frm_err_q <= 1'b0;
      end else begin
         par_vld_q <= 1'b0;
         frm_err_q <= 1'b0;
         if (bus.srl_vld) begin
            unique case (state_q)
               StHunt: begin
                  if (bus.frm) begin
                     sh_q    <= start_word;
                     cnt_q   <= CntW'(1);
                     state_q <= StRecv;
                  end
               end
               StRecv: begin
                  if (bus.frm && (cnt_q != '0)) begin
                     // Misplaced word start: drop the partial word, restart on this bit.
                     frm_err_q <= 1'b1;
                     sh_q      <= start_word;
                     cnt_q     <= CntW'(1);
                  end else begin
                     sh_q <= ins_word;
                     if (last_bit) begin
                        par_q     <= ins_word;
                        par_vld_q <= 1'b1;
                        cnt_q     <= '0;
                     end else begin
                        cnt_q <= cnt_q + CntW'(1);
                     end
                  end
               end
               default: state_q <= StHunt;
            endcase
         end
      end
   end

   assign bus.par     = par_q;
   assign bus.par_vld = par_vld_q;
   assign bus.locked  = (state_q == StRecv);
   assign bus.frm_err = frm_err_q;

endmodule

// File: tb/tb_srl2par.sv
// Directed bench for srl2par: LSB-first and MSB-first instances share one serial
// stream; a vector table covers the per-cycle behaviour, hand sequences cover reset.
module tb_srl2par;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fails  = 0;

   always #5 clk = ~clk;

   srl2par_if #(.WIDTH(4)) if0 ();
   srl2par_if #(.WIDTH(4)) if1 ();

   srl2par #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   srl2par #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   typedef struct {
      logic       srl;
      logic       vld;
      logic       frm;
      logic       pv;
      logic       lk;
      logic       err;
      logic [3:0] p0;
      logic [3:0] p1;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic s, input logic v, input logic f, input logic pv,
                      input logic lk, input logic err, input logic [3:0] p0,
                      input logic [3:0] p1);
      vec_t e;
      e.srl = s; e.vld = v; e.frm = f; e.pv = pv; e.lk = lk; e.err = err;
      e.p0 = p0; e.p1 = p1;
      vecs.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic drive(input logic s, input logic v, input logic f);
      if0.srl = s; if0.srl_vld = v; if0.frm = f;
      if1.srl = s; if1.srl_vld = v; if1.frm = f;
   endtask

   task automatic step(input logic s, input logic v, input logic f);
      drive(s, v, f);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic pv, input logic lk,
                            input logic err, input logic [3:0] p0, input logic [3:0] p1);
      check({tag, " par_vld0"}, 32'(if0.par_vld), 32'(pv));
      check({tag, " locked0"},  32'(if0.locked),  32'(lk));
      check({tag, " frm_err0"}, 32'(if0.frm_err), 32'(err));
      check({tag, " par0"},     32'(if0.par),     32'(p0));
      check({tag, " par_vld1"}, 32'(if1.par_vld), 32'(pv));
      check({tag, " locked1"},  32'(if1.locked),  32'(lk));
      check({tag, " frm_err1"}, 32'(if1.frm_err), 32'(err));
      check({tag, " par1"},     32'(if1.par),     32'(p1));
   endtask

   initial begin
      // Hunt: stray bits ignored, then word 0,1,0,0.
      add(1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
      add(1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
      add(0, 1, 1, 0, 1, 0, 4'b0000, 4'b0000);
      add(1, 1, 0, 0, 1, 0, 4'b0000, 4'b0000);
      add(0, 1, 0, 0, 1, 0, 4'b0000, 4'b0000);
      add(0, 1, 0, 1, 1, 0, 4'b0010, 4'b0100);
      // Word 1,0,1,1.
      add(1, 1, 1, 0, 1, 0, 4'b0010, 4'b0100);
      add(0, 1, 0, 0, 1, 0, 4'b0010, 4'b0100);
      add(1, 1, 0, 0, 1, 0, 4'b0010, 4'b0100);
      add(1, 1, 0, 1, 1, 0, 4'b1101, 4'b1011);
      // Free-run: frm only on first of 8 bits 1,0,0,0,0,1,1,1.
      add(1, 1, 1, 0, 1, 0, 4'b1101, 4'b1011);
      add(0, 1, 0, 0, 1, 0, 4'b1101, 4'b1011);
      add(0, 1, 0, 0, 1, 0, 4'b1101, 4'b1011);
      add(0, 1, 0, 1, 1, 0, 4'b0001, 4'b1000);
      add(0, 1, 0, 0, 1, 0, 4'b0001, 4'b1000);
      add(1, 1, 0, 0, 1, 0, 4'b0001, 4'b1000);
      add(1, 1, 0, 0, 1, 0, 4'b0001, 4'b1000);
      add(1, 1, 0, 1, 1, 0, 4'b1110, 4'b0111);
      // frm again at index 2, then 3 more bits: new word 0,1,0,1.
      add(1, 1, 1, 0, 1, 0, 4'b1110, 4'b0111);
      add(1, 1, 0, 0, 1, 0, 4'b1110, 4'b0111);
      add(0, 1, 1, 0, 1, 1, 4'b1110, 4'b0111);
      add(1, 1, 0, 0, 1, 0, 4'b1110, 4'b0111);
      add(0, 1, 0, 0, 1, 0, 4'b1110, 4'b0111);
      add(1, 1, 0, 1, 1, 0, 4'b1010, 4'b0101);
      // Gapped word 1,0,1,1; idle cycles carry frm=1 that must be ignored.
      add(1, 1, 1, 0, 1, 0, 4'b1010, 4'b0101);
      add(0, 0, 1, 0, 1, 0, 4'b1010, 4'b0101);
      add(0, 1, 0, 0, 1, 0, 4'b1010, 4'b0101);
      add(0, 0, 1, 0, 1, 0, 4'b1010, 4'b0101);
      add(1, 1, 0, 0, 1, 0, 4'b1010, 4'b0101);
      add(0, 0, 1, 0, 1, 0, 4'b1010, 4'b0101);
      add(1, 1, 0, 1, 1, 0, 4'b1101, 4'b1011);
      // frm at index WIDTH-1: error, no completion; restart gives 1,0,0,1.
      add(0, 1, 1, 0, 1, 0, 4'b1101, 4'b1011);
      add(1, 1, 0, 0, 1, 0, 4'b1101, 4'b1011);
      add(1, 1, 0, 0, 1, 0, 4'b1101, 4'b1011);
      add(1, 1, 1, 0, 1, 1, 4'b1101, 4'b1011);
      add(0, 1, 0, 0, 1, 0, 4'b1101, 4'b1011);
      add(0, 1, 0, 0, 1, 0, 4'b1101, 4'b1011);
      add(1, 1, 0, 1, 1, 0, 4'b1001, 4'b1001);

      drive(0, 0, 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset", 0, 0, 0, 4'b0000, 4'b0000);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].srl, vecs[i].vld, vecs[i].frm);
         check_all($sformatf("vec%0d", i), vecs[i].pv, vecs[i].lk, vecs[i].err,
                   vecs[i].p0, vecs[i].p1);
      end

      // Asynchronous reset mid-word: outputs clear without a clock edge.
      step(1, 1, 1);
      step(1, 1, 0);
      #2;
      rst = 1'b1;
      #1;
      check_all("async_rst", 0, 0, 0, 4'b0000, 4'b0000);
      drive(0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      // Without frm the block stays in hunt and delivers nothing.
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 0);
         check_all($sformatf("post_rst_hunt%0d", i), 0, 0, 0, 4'b0000, 4'b0000);
      end
      step(0, 1, 1);
      check_all("post_rst_b0", 0, 1, 0, 4'b0000, 4'b0000);
      step(1, 1, 0);
      step(1, 1, 0);
      check_all("post_rst_b2", 0, 1, 0, 4'b0000, 4'b0000);
      step(0, 1, 0);
      check_all("post_rst_done", 1, 1, 0, 4'b0110, 4'b0110);
      step(0, 0, 0);
      check_all("pulse_drop", 0, 1, 0, 4'b0110, 4'b0110);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
